// File: rtl/count_updn.sv
// Parametrised up/down counter: programmable modulus, parallel load, enable prescaler, tc/wrap flags.
// Define COUNT_SATURATE_EN to hold at the boundary instead of wrapping (wrap still pulses).
module count_updn #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [WIDTH-1:0] MAX      = WIDTH'(MAX_VAL);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;
  logic             tick;
  logic             at_bound;

  assign tick     = en && (pre == PRE_LAST);
  assign at_bound = up ? (out == MAX) : (out == '0);

  // tc is purely a function of the current count and direction, for cascading.
  assign tc = at_bound;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    pre_nxt  = pre;
    out_nxt  = out;
    wrap_nxt = 1'b0;

    if (load) begin
      // Clamping here keeps the counter from ever holding a value above MAX.
      out_nxt = (load_val > MAX) ? MAX : load_val;
      pre_nxt = '0;
    end else if (en) begin
      pre_nxt = tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (at_bound) begin
          wrap_nxt = 1'b1;
`ifdef COUNT_SATURATE_EN
          out_nxt  = out;
`else
          out_nxt  = up ? '0 : MAX;
`endif
        end else begin
          out_nxt = up ? out + 1'b1 : out - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (rst) begin
      out  <= '0;
      pre  <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      pre  <= pre_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_count_updn.sv
// Self-checking bench for count_updn: two instances (DIV=1 and DIV=3, MAX_VAL=9) share stimulus
// and are compared against an arithmetic reference model each cycle.
module tb_count_updn;

  localparam int W  = 4;
  localparam int MV = 9;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] out_w [2];
  logic         tc_w  [2];
  logic         wrap_w[2];

  int vectors    = 0;
  int miscompares = 0;

  int m_cnt [2];
  int m_pre [2];
  int m_wrap[2];
  int divs  [2] = '{1, 3};

  always #5 clk = ~clk;

  count_updn #(.WIDTH(W), .MAX_VAL(MV), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_w[0]), .tc(tc_w[0]), .wrap(wrap_w[0])
  );

  count_updn #(.WIDTH(W), .MAX_VAL(MV), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_w[1]), .tc(tc_w[1]), .wrap(wrap_w[1])
  );

  // Reference: count lives in 0..MV, a step is modular (or saturating) arithmetic on an int.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      if (rst) begin
        m_cnt[i] = 0;
        m_pre[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MV) ? MV : int'(load_val);
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i]++;
        if (m_pre[i] == divs[i]) begin
          int nxt;
          m_pre[i] = 0;
          nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
          if (nxt > MV || nxt < 0) begin
            m_wrap[i] = 1;
`ifdef COUNT_SATURATE_EN
            nxt = m_cnt[i];
`else
            nxt = (nxt + MV + 1) % (MV + 1);
`endif
          end
          m_cnt[i] = nxt;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] exp_out;
      logic         exp_tc, exp_wrap;
      exp_out  = W'(m_cnt[i]);
      exp_wrap = (m_wrap[i] != 0);
      exp_tc   = up ? (m_cnt[i] == MV) : (m_cnt[i] == 0);
      vectors++;
      assert (out_w[i] === exp_out) else begin
        miscompares++;
        $error("FAIL %s dut%0d out: got %0d want %0d", tag, i, out_w[i], exp_out);
      end
      vectors++;
      assert (wrap_w[i] === exp_wrap) else begin
        miscompares++;
        $error("FAIL %s dut%0d wrap: got %b want %b", tag, i, wrap_w[i], exp_wrap);
      end
      vectors++;
      assert (tc_w[i] === exp_tc) else begin
        miscompares++;
        $error("FAIL %s dut%0d tc: got %b want %b", tag, i, tc_w[i], exp_tc);
      end
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input int lv);
    rst = r; en = e; up = u; load = l; load_val = W'(lv);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
    end

    // Reset held two cycles with en/up active.
    drive(1, 1, 1, 0, 0);
    cycle("reset0");
    cycle("reset1");

    // Up count 1..9,0 with wrap on return to 0.
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 11; k++) cycle("up_count");

    // Down count through the 0 -> 9 boundary.
    drive(1, 0, 0, 0, 0);
    cycle("down_rst");
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) cycle("down_count");

    // Load clamp, then load with en high (no step that cycle).
    drive(0, 0, 1, 1, 13);
    cycle("load_clamp");
    drive(0, 1, 1, 1, 4);
    cycle("load_en");
    drive(0, 0, 1, 0, 4);
    cycle("load_hold");

    // Prescaler: 9 enabled cycles, then 2 enabled, 5 idle, enabled again.
    drive(1, 0, 1, 0, 0);
    cycle("pre_rst");
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 9; k++) cycle("pre_run");
    drive(1, 0, 1, 0, 0);
    cycle("pre_rst2");
    drive(0, 1, 1, 0, 0);
    cycle("pre_en1");
    cycle("pre_en2");
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cycle("pre_idle");
    drive(0, 1, 1, 0, 0);
    cycle("pre_resume");
    cycle("pre_resume2");

    // Reset beats load; load beats a boundary tick.
    drive(1, 1, 1, 1, 5);
    cycle("rst_over_load");
    drive(0, 0, 1, 1, 9);
    cycle("load9");
    drive(0, 1, 1, 1, 2);
    cycle("load_over_wrap");

    // Boundary behaviour from 8 upward (wrap or saturate depending on build).
    drive(0, 0, 1, 1, 8);
    cycle("load8");
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle("boundary_up");
    drive(0, 0, 0, 1, 1);
    cycle("load1");
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle("boundary_down");

    // Randomised traffic, including mid-count direction changes.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0), $urandom_range(0, 15));
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
